// File: rtl/song_sequencer.sv
// song_sequencer: steps through a song memory, holding each note for its beat count followed by a silent gap.
module song_sequencer #(
    parameter logic [31:0] BEAT_CYCLES = 32'd25000000,
    parameter logic [31:0] GAP_CYCLES  = 32'd2500000,
    parameter int          ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic [6:0]        note,
    output logic              playing,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, FINISH} state_t;
    state_t            r_state, w_next;
    logic [31:0]       r_cnt, w_cnt;
    logic [2:0]        r_beats, w_beats;
    logic [6:0]        r_code, w_code;
    logic [ADDR_W-1:0] w_addr;
    // next-state, counter, latched-code and address decisions; stop overrides everything
    always_comb begin
        w_next  = r_state;
        w_cnt   = r_cnt;
        w_beats = r_beats;
        w_code  = r_code;
        w_addr  = rom_addr;
        case (r_state)
            IDLE:  w_next = start ? FETCH : IDLE;
            FETCH: w_next = LOAD;
            LOAD: begin
                w_cnt   = 32'd0;
                w_beats = rom_data[9:7];
                w_code  = (rom_data[6:0] <= 7'd21) ? rom_data[6:0] : 7'd0;
                w_next  = (rom_data[6:0] == 7'd127) ? FINISH : PLAY;
            end
            PLAY: begin
                if (!pause) begin
                    if (r_cnt == BEAT_CYCLES - 32'd1) begin
                        w_cnt = 32'd0;
                        if (r_beats == 3'd0) w_next = GAP;
                        else w_beats = r_beats - 3'd1;
                    end else begin
                        w_cnt = r_cnt + 32'd1;
                    end
                end
            end
            GAP: begin
                if (!pause) begin
                    if (r_cnt == GAP_CYCLES - 32'd1) begin
                        w_cnt = 32'd0;
                        if (&rom_addr) begin
                            w_next = FINISH;
                        end else begin
                            w_addr = rom_addr + ADDR_W'(1);
                            w_next = FETCH;
                        end
                    end else begin
                        w_cnt = r_cnt + 32'd1;
                    end
                end
            end
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (stop) w_next = IDLE;
        if (w_next == IDLE) begin
            w_addr  = '0;
            w_cnt   = 32'd0;
            w_beats = 3'd0;
            w_code  = 7'd0;
        end
    end
    // state, counters and all outputs registered from the next-state decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 32'd0;
            r_beats  <= 3'd0;
            r_code   <= 7'd0;
            rom_addr <= '0;
            note     <= 7'd0;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt;
            r_beats  <= w_beats;
            r_code   <= w_code;
            rom_addr <= w_addr;
            note     <= (w_next == PLAY && !pause) ? w_code : 7'd0;
            playing  <= (w_next != IDLE);
            done     <= (w_next == FINISH);
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: vector tables and corner-case sequences for song_sequencer.
module tb_song_sequencer;
    typedef struct {
        logic       st, sp, pa;
        logic [6:0] n;
        logic       p, d;
        logic [7:0] a;
    } vec_t;

    logic       clk = 0, rst_n = 1, start = 0, stop = 0, pause = 0;
    logic [7:0] rom_addr;
    logic [9:0] rom_data = '0;
    logic [6:0] note;
    logic       playing, done;
    logic       start2 = 0;
    logic [1:0] rom_addr2;
    logic [9:0] rom_data2 = '0;
    logic [6:0] note2;
    logic       playing2, done2;
    logic [9:0] mem [256];
    logic [9:0] mem2 [4];
    vec_t       q [$];
    int         n_pass = 0, n_total = 0;

    song_sequencer #(.BEAT_CYCLES(32'd4), .GAP_CYCLES(32'd2), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .playing(playing), .done(done));

    song_sequencer #(.BEAT_CYCLES(32'd4), .GAP_CYCLES(32'd2), .ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(1'b0), .pause(1'b0),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .note(note2), .playing(playing2), .done(done2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= mem[rom_addr];
        rom_data2 <= mem2[rom_addr2];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic add_n(input int cnt, input logic st, sp, pa, input int n, input logic p, d, input int a);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.n = 7'(n); v.p = p; v.d = d; v.a = 8'(a);
        for (int i = 0; i < cnt; i++) q.push_back(v);
    endtask

    task automatic run_q(input string seg);
        foreach (q[i]) begin
            start = q[i].st; stop = q[i].sp; pause = q[i].pa;
            @(posedge clk); #1;
            chk($sformatf("%s v%0d note", seg, i), int'(note), int'(q[i].n));
            chk($sformatf("%s v%0d playing", seg, i), int'(playing), int'(q[i].p));
            chk($sformatf("%s v%0d done", seg, i), int'(done), int'(q[i].d));
            chk($sformatf("%s v%0d addr", seg, i), int'(rom_addr), int'(q[i].a));
        end
        start = 0; stop = 0; pause = 0;
        q.delete();
    endtask

    initial begin
        int entries, dones, cyc;
        logic [6:0] prev;
        for (int i = 0; i < 256; i++) mem[i] = 10'd0;
        for (int i = 0; i < 4; i++) mem2[i] = {3'd0, 7'd1};
        mem[0] = {3'd0, 7'd8};
        mem[1] = {3'd1, 7'd8};
        mem[2] = {3'd0, 7'd127};
        #2 rst_n = 0;
        #1;
        chk("reset note", int'(note), 0);
        chk("reset playing", int'(playing), 0);
        chk("reset done", int'(done), 0);
        chk("reset addr", int'(rom_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle after reset release", int'(playing), 0);

        add_n(1, 1, 0, 0, 0, 1, 0, 0);
        add_n(1, 0, 0, 0, 0, 1, 0, 0);
        add_n(4, 0, 0, 0, 8, 1, 0, 0);
        add_n(2, 0, 0, 0, 0, 1, 0, 0);
        add_n(2, 0, 0, 0, 0, 1, 0, 1);
        add_n(2, 0, 0, 0, 8, 1, 0, 1);
        add_n(1, 1, 0, 0, 8, 1, 0, 1);
        add_n(5, 0, 0, 0, 8, 1, 0, 1);
        add_n(2, 0, 0, 0, 0, 1, 0, 1);
        add_n(2, 0, 0, 0, 0, 1, 0, 2);
        add_n(1, 0, 0, 0, 0, 1, 1, 2);
        add_n(2, 0, 0, 0, 0, 0, 0, 0);
        run_q("song");

        add_n(1, 1, 0, 0, 0, 1, 0, 0);
        add_n(1, 0, 0, 0, 0, 1, 0, 0);
        add_n(2, 0, 0, 0, 8, 1, 0, 0);
        add_n(10, 0, 0, 1, 0, 1, 0, 0);
        add_n(2, 0, 0, 0, 8, 1, 0, 0);
        add_n(2, 0, 0, 0, 0, 1, 0, 0);
        add_n(1, 0, 1, 0, 0, 0, 0, 0);
        add_n(2, 0, 0, 0, 0, 0, 0, 0);
        run_q("pause");

        add_n(1, 1, 0, 0, 0, 1, 0, 0);
        add_n(1, 0, 0, 0, 0, 1, 0, 0);
        add_n(2, 0, 0, 0, 8, 1, 0, 0);
        add_n(1, 0, 1, 0, 0, 0, 0, 0);
        add_n(3, 0, 0, 0, 0, 0, 0, 0);
        add_n(1, 1, 1, 0, 0, 0, 0, 0);
        add_n(2, 0, 0, 0, 0, 0, 0, 0);
        run_q("stop");

        mem[0] = {3'd2, 7'd50};
        mem[1] = {3'd0, 7'd5};
        mem[2] = {3'd0, 7'd127};
        add_n(1, 1, 0, 0, 0, 1, 0, 0);
        add_n(15, 0, 0, 0, 0, 1, 0, 0);
        add_n(2, 0, 0, 0, 0, 1, 0, 1);
        add_n(4, 0, 0, 0, 5, 1, 0, 1);
        add_n(2, 0, 0, 0, 0, 1, 0, 1);
        add_n(2, 0, 0, 0, 0, 1, 0, 2);
        add_n(1, 0, 0, 0, 0, 1, 1, 2);
        add_n(1, 0, 0, 0, 0, 0, 0, 0);
        run_q("rest");

        start2 = 1;
        @(posedge clk); #1;
        start2 = 0;
        entries = 0; dones = 0; cyc = 0; prev = 7'd0;
        while (playing2 && cyc < 200) begin
            if (note2 != 7'd0 && prev == 7'd0) entries++;
            if (done2) dones++;
            prev = note2;
            @(posedge clk); #1;
            cyc++;
        end
        chk("wrap finished in time", int'(cyc < 200), 1);
        chk("wrap entries", entries, 4);
        chk("wrap done pulses", dones, 1);
        chk("wrap addr", int'(rom_addr2), 0);

        mem[0] = {3'd0, 7'd8};
        mem[1] = {3'd1, 7'd8};
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre-reset in gap playing", int'(playing), 1);
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("async reset note", int'(note), 0);
        chk("async reset playing", int'(playing), 0);
        chk("async reset done", int'(done), 0);
        chk("async reset addr", int'(rom_addr), 0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("no self start playing", int'(playing), 0);
        chk("no self start note", int'(note), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 25000000, clock cycles per beat (0.25 s at 100 MHz); legal range 1..2^32-1.
REQ-002 SHALL have parameter GAP_CYCLES, default 2500000, silent cycles inserted after every entry; legal range 1..2^32-1.
REQ-003 SHALL have parameter ADDR_W, default 8, song memory address width.
REQ-004 clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin playback from address 0; sampled high for one cycle.
REQ-007 stop  input  1  abort playback; sampled high for one cycle.
REQ-008 pause  input  1  level; high freezes playback timing and silences the output.
REQ-009 rom_addr  output  ADDR_W  song memory read address; the memory returns data one cycle later.
REQ-010 rom_data  input  10  memory entry: [6:0] note code (0 rest, 1..21 C3..B5, 127 end marker); [9:7] duration in beats minus 1.
REQ-011 note  output  7  registered note code for the downstream tone generator; 0 means silence.
REQ-012 playing  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a song ends normally.

Function
REQ-014 SHALL implement the states IDLE, FETCH, LOAD, PLAY, GAP and FINISH.
REQ-015 IDLE: note=0, rom_addr=0; start -> FETCH.
REQ-016 FETCH: rom_addr drives the current address; next state is always LOAD.
REQ-017 LOAD: decode rom_data as follows.
- Code 127 -> FINISH.
- Code 0..21 -> latch the code into note, then PLAY.
- Code 22..126 -> note=0 (treated as a rest), then PLAY.
REQ-018 Timing: start is sampled at edge E0; the first entry's note is valid from edge E2 onward.
REQ-019 PLAY SHALL last exactly (rom_data[9:7]+1)*BEAT_CYCLES unpaused cycles, then transition to GAP.
REQ-020 The PLAY duration SHALL be counted with a beat counter plus a beats-remaining counter; no multiplier is used.
REQ-021 GAP: note=0 for GAP_CYCLES unpaused cycles, so that repeated identical notes retrigger the tone generator.
REQ-022 Leaving GAP, the sequencer SHALL go to FINISH if the address equals 2^ADDR_W-1; otherwise it SHALL increment the address and go to FETCH.
REQ-023 FINISH: done=1 for exactly one cycle, note=0, then IDLE with address 0.
REQ-024 Pause in PLAY or GAP: both counters hold and note=0. When pause is released, the latched note is restored and counting resumes where it stopped; no entry time is lost or gained.
REQ-025 Pause in FETCH or LOAD: has no effect on those states; the pause takes effect on entering PLAY.
REQ-026 Stop has the highest priority: from any non-IDLE state, the sequencer enters IDLE on the next edge. There it drives note=0, rom_addr=0 and playing=0, and no done pulse is produced.
REQ-027 start while playing=1 SHALL be ignored.
REQ-028 start and stop asserted in the same cycle SHALL leave the sequencer in IDLE.
REQ-029 note, playing, done and rom_addr SHALL all be registered outputs with no combinational path from any input.

Reset
REQ-030 rst_n low SHALL immediately, without waiting for a clock edge, force the following:
- state IDLE, address 0, all counters 0;
- note=0, playing=0, done=0, rom_addr=0.
REQ-031 Release of rst_n SHALL leave the block in IDLE; it SHALL wait for start and never start playback by itself.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2)
REQ-032 Song memory {8/dur0, 8/dur1, 127}, start pulse:
- note=8 for 4 cycles, 0 for 2 cycles, 8 for 8 cycles, 0 for 2 cycles;
- then the 127 entry is fetched, done pulses once and playing falls.
REQ-033 pause held for 10 cycles during the second PLAY cycle of a dur0 entry: note=0 during the pause, and total note=8 cycles remain exactly 4.
REQ-034 stop during PLAY: on the next edge note=0, playing=0 and rom_addr=0, and done never pulses.
REQ-035 Entry code 50 with dur2: note=0 for 12 cycles plus 2 gap cycles, then the next entry plays normally.
REQ-036 ADDR_W=2 with no end marker in memory: exactly 4 entries play, then done pulses once and rom_addr returns to 0.
REQ-037 Reset and start edge cases:
- rst_n pulsed low mid-GAP between clock edges: outputs reach reset values before the next edge.
- start during playback: no effect.
- start and stop together in IDLE: the block remains in IDLE.
